dmem_arbiter: RTL and testbench

//   Shares the single-port M-stage data memory between the pipeline (CPU port) and a DMA/debug port.
//   CPU has fixed priority; an anti-starvation counter guarantees DMA progress.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arb_starve_ctr.sv | 33 +++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_owner_e;

    localparam int         STARVE_CNT_W = 4;
    localparam logic [1:0] ALIGN_MASK   = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request, same-cycle grant, registered response.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              stall;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, write, addr, wdata,
        input  gnt, stall, rsp_valid, rdata
    );

    modport slave (
        input  req, write, addr, wdata,
        output gnt, stall, rsp_valid, rdata
    );
endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive cycles the DMA port waits; raises force_dma once the limit is reached.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);
    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (dma_gnt) begin
            cnt <= '0;
        end else if (dma_req) begin
            if (cnt != LIMIT) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign force_dma = (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU fixed priority, DMA anti-starvation slot, registered responses.
// Optional misalignment check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dma,
    output logic              rsp_err,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    gnt_owner_e        owner;
    logic              force_dma;
    logic              sel_write;
    logic              misaligned;
    logic [DATA_W-1:0] load_data;

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .dma_req   (dma.req),
        .dma_gnt   (dma.gnt),
        .force_dma (force_dma)
    );

    // Grants are held off during reset so no access can reach memory in that cycle.
    always_comb begin
        owner = GNT_NONE;
        if (!reset) begin
            if (force_dma && dma.req) begin
                owner = GNT_DMA;
            end else if (cpu.req) begin
                owner = GNT_CPU;
            end else if (dma.req) begin
                owner = GNT_DMA;
            end
        end
    end

    assign cpu.gnt   = (owner == GNT_CPU);
    assign dma.gnt   = (owner == GNT_DMA);
    assign cpu.stall = cpu.req & ~cpu.gnt;
    assign dma.stall = dma.req & ~dma.gnt;

    always_comb begin
        sel_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (owner)
            GNT_CPU: begin
                sel_write      = cpu.write;
                mem_address    = cpu.addr;
                mem_write_data = cpu.wdata;
            end
            GNT_DMA: begin
                sel_write      = dma.write;
                mem_address    = dma.addr;
                mem_write_data = dma.wdata;
            end
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (owner != GNT_NONE) && is_misaligned(mem_address[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    assign mem_write = sel_write & ~misaligned;
    assign load_data = (sel_write || misaligned) ? '0 : mem_read_data;

    // rdata holds its last value between responses; only meaningful with rsp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu.rsp_valid <= 1'b0;
            dma.rsp_valid <= 1'b0;
            cpu.rdata     <= '0;
            dma.rdata     <= '0;
        end else begin
            cpu.rsp_valid <= cpu.gnt;
            dma.rsp_valid <= dma.gnt;
            if (cpu.gnt) begin
                cpu.rdata <= load_data;
            end
            if (dma.gnt) begin
                dma.rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model (word-array memory, wait counter, next-cycle responses).
module tb_dmem_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dma_if ();

    logic        rsp_err;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu            (cpu_if),
        .dma            (dma_if),
        .rsp_err        (rsp_err),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Data memory seen by the DUT, plus the model's own copy.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_address[7:2]] = mem_write_data;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Model state
    bit          chk_en = 1'b0;
    int          m_wait = 0;
    bit          e_cv = 1'b0, e_dv = 1'b0, e_err = 1'b0;
    logic [31:0] e_crd = '0, e_drd = '0;

    always @(negedge clk) begin
        bit          ec, ed, ew, g, m;
        logic [31:0] ea, ewd, ld;
        if (chk_en) begin
            ed = !reset && dma_if.req && (m_wait == LIMIT || !cpu_if.req);
            ec = !reset && cpu_if.req && !ed;
            ea = '0; ewd = '0; ew = 1'b0;
            if (ec) begin
                ea = cpu_if.addr; ewd = cpu_if.wdata; ew = cpu_if.write;
            end else if (ed) begin
                ea = dma_if.addr; ewd = dma_if.wdata; ew = dma_if.write;
            end
            g = ec || ed;
            m = g && mis(ea);

            check("cpu_gnt", cpu_if.gnt, ec);
            check("dma_gnt", dma_if.gnt, ed);
            check("cpu_stall", cpu_if.stall, cpu_if.req && !ec);
            check("mem_address", mem_address, ea);
            check("mem_write", mem_write, ew && !m);
            check("mem_write_data", mem_write_data, ewd);
            check("cpu_rsp_valid", cpu_if.rsp_valid, e_cv);
            check("dma_rsp_valid", dma_if.rsp_valid, e_dv);
            check("rsp_err", rsp_err, e_err);
            if (e_cv) check("cpu_rdata", cpu_if.rdata, e_crd);
            if (e_dv) check("dma_rdata", dma_if.rdata, e_drd);

            ld = (ew || m) ? 32'h0 : ref_mem[ea[7:2]];
            if (g && ew && !m) ref_mem[ea[7:2]] = ewd;
            e_cv  = ec;
            e_dv  = ed;
            e_err = m;
            if (ec) e_crd = ld;
            if (ed) e_drd = ld;
            if (reset || ed || !dma_if.req) m_wait = 0;
            else if (m_wait < LIMIT) m_wait = m_wait + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic set_cpu(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        cpu_if.req = r; cpu_if.write = w; cpu_if.addr = a; cpu_if.wdata = d;
    endtask

    task automatic set_dma(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        dma_if.req = r; dma_if.write = w; dma_if.addr = a; dma_if.wdata = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit cg, dg;
        int waits;
        for (int i = 0; i < 64; i++) preload(i, 32'hA5A5_0000 ^ (i * 32'h0101_0101));
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_cpu_rsp_valid", cpu_if.rsp_valid, 0);
        check("rst_dma_rsp_valid", dma_if.rsp_valid, 0);
        check("rst_cpu_rdata", cpu_if.rdata, 0);
        check("rst_dma_rdata", dma_if.rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        step();
        reset = 1'b0;

        // 1: CPU-only load
        preload(4, 32'hDEAD_BEEF);
        set_cpu(1, 0, 32'h10, 0);
        @(negedge clk);
        check("t1_cpu_gnt", cpu_if.gnt, 1);
        check("t1_cpu_stall", cpu_if.stall, 0);
        step();
        set_cpu(0, 0, 0, 0);
        @(negedge clk);
        check("t1_cpu_rsp_valid", cpu_if.rsp_valid, 1);
        check("t1_cpu_rdata", cpu_if.rdata, 32'hDEAD_BEEF);

        // 2: DMA-only store then readback
        step();
        set_dma(1, 1, 32'h20, 32'h1234);
        @(negedge clk);
        check("t2_dma_gnt", dma_if.gnt, 1);
        check("t2_mem_write", mem_write, 1);
        step();
        set_dma(1, 0, 32'h20, 0);
        @(negedge clk);
        check("t2_store_rsp_valid", dma_if.rsp_valid, 1);
        check("t2_store_rdata", dma_if.rdata, 0);
        check("t2_load_mem_write", mem_write, 0);
        step();
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        check("t2_load_rsp_valid", dma_if.rsp_valid, 1);
        check("t2_readback", dma_if.rdata, 32'h1234);

        // 3: continuous contention, DMA forced every 5th cycle
        step();
        do_reset();
        set_cpu(1, 0, 32'h40, 0);
        set_dma(1, 0, 32'h44, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("t3_dma_gnt_%0d", c), dma_if.gnt, (c % 5) == 4);
            check($sformatf("t3_cpu_stall_%0d", c), cpu_if.stall, (c % 5) == 4);
            step();
        end

        // 4: reset in the cycle after a grant, with a store pending during reset
        preload(12, 32'h0C0C_0C0C);
        reset = 1'b1;
        set_cpu(1, 1, 32'h30, 32'h0000_0BAD);
        set_dma(0, 0, 0, 0);
        @(negedge clk);
        check("t4_rst_cpu_gnt", cpu_if.gnt, 0);
        check("t4_rst_mem_write", mem_write, 0);
        step();
        reset = 1'b0;
        set_cpu(0, 0, 0, 0);
        @(negedge clk);
        check("t4_cpu_rsp_valid", cpu_if.rsp_valid, 0);
        check("t4_dma_rsp_valid", dma_if.rsp_valid, 0);
        check("t4_cpu_rdata", cpu_if.rdata, 0);
        check("t4_mem_address", mem_address, 0);
        check("t4_mem_unchanged", mem[12], 32'h0C0C_0C0C);
        step();
        set_cpu(1, 0, 32'h40, 0);
        set_dma(1, 0, 32'h44, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t4_cnt_cleared_%0d", c), dma_if.gnt, c == 4);
            step();
        end
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);

        // 5: misaligned CPU store to 0x22
        preload(8, 32'h1111_2222);
        step();
        set_cpu(1, 1, 32'h22, 32'h5555_AAAA);
        @(negedge clk);
`ifdef DMEM_ALIGN_CHECK_EN
        check("t5_mem_write", mem_write, 0);
`else
        check("t5_mem_write", mem_write, 1);
`endif
        step();
        set_cpu(0, 0, 0, 0);
        @(negedge clk);
        check("t5_cpu_rsp_valid", cpu_if.rsp_valid, 1);
`ifdef DMEM_ALIGN_CHECK_EN
        check("t5_rsp_err", rsp_err, 1);
        check("t5_word8", mem[8], 32'h1111_2222);
`else
        check("t5_rsp_err", rsp_err, 0);
        check("t5_word8", mem[8], 32'h5555_AAAA);
`endif

        // 6: DMA drops after 3 waits, then must wait the full limit again
        step();
        do_reset();
        set_cpu(1, 0, 32'h40, 0);
        set_dma(1, 0, 32'h44, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("t6_wait_gnt_%0d", c), dma_if.gnt, 0);
            step();
        end
        set_dma(0, 0, 0, 0);
        step();
        set_dma(1, 0, 32'h48, 0);
        waits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dma_if.gnt) break;
            waits++;
            step();
        end
        check("t6_waits", waits, LIMIT);
        step();
        set_cpu(0, 0, 0, 0);
        set_dma(0, 0, 0, 0);

        // Random traffic, requests held until granted, occasional DMA drops and resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cg = cpu_if.gnt;
            dg = dma_if.gnt;
            step();
            reset = ($urandom % 200) == 0;
            if (!(cpu_if.req && !cg)) begin
                if (($urandom % 4) != 0)
                    set_cpu(1, 1'($urandom % 2),
                            {24'h0, 6'($urandom_range(0, 63)), (($urandom % 8) == 0) ? 2'($urandom) : 2'b00},
                            $urandom);
                else
                    set_cpu(0, 0, 0, 0);
            end
            if (dma_if.req && !dg) begin
                if (($urandom % 16) == 0) set_dma(0, 0, 0, 0);
            end else if (($urandom % 2) == 0) begin
                set_dma(1, 1'($urandom % 2),
                        {24'h0, 6'($urandom_range(0, 63)), (($urandom % 8) == 0) ? 2'($urandom) : 2'b00},
                        $urandom);
            end else begin
                set_dma(0, 0, 0, 0);
            end
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
